sdram_arbiter: RTL and testbench

Two-port arbiter that shares the single `sdram_ctrl` instance between the camera pixel writer (write port) and the display fetcher (read port). It sequences one SDRAM transaction at a time. It applies round-robin priority on contention and drives the controller's single-cycle `i_sdram_en` command handshake. It sits between the OV7670 capture/VGA scan logic and `sdram_ctrl`, on the controller's 133 MHz clock.

---
 rtl/sdram_arbiter.sv | 151 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one sdram_ctrl between the camera write port and the display read port.
// One transaction in flight at a time; all outputs registered; sticky timeout on a stalled controller.
//
// state         | meaning
// S_IDLE        | waiting for controller ready and a request; arbitrates and latches the command
// S_ISSUE       | o_ctrl_en high for this single cycle
// S_WAIT_ACCEPT | waiting for the controller to drop ready (command taken)
// S_WAIT_DONE   | read: waiting for dataval; write: waiting for ready to return
// S_ACK         | ack pulse on the granted port; last_grant updated
module sdram_arbiter #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_ctrl_addr,
  output logic [DATA_W-1:0] o_ctrl_datain,
  output logic              o_ctrl_rw,
  output logic              o_ctrl_en,
  input  logic              i_ctrl_ready,
  input  logic              i_ctrl_dataval,
  input  logic [DATA_W-1:0] i_ctrl_dataout,
  output logic              o_busy,
  output logic              o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_rd;
  logic              r_ctrl_en;
  logic [ADDR_W-1:0] r_ctrl_addr;
  logic [DATA_W-1:0] r_ctrl_datain;
  logic              r_ctrl_rw;
  logic              r_wr_ack;
  logic              r_rd_ack;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_busy;
  logic              r_timeout;

  logic w_grant_go;
  logic w_grant_rd;
  logic w_done;
  logic w_expired;
  logic w_in_wait;
  logic w_enter_wait;
  logic w_to_ack;
  logic w_abort;
  logic w_capture;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Completion wins over timeout when both are seen in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:        if (w_grant_go) w_next = S_ISSUE;
      S_ISSUE:       w_next = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT: begin
        if (!i_ctrl_ready)  w_next = S_WAIT_DONE;
        else if (w_expired) w_next = S_ACK;
      end
      S_WAIT_DONE:   if (w_done || w_expired) w_next = S_ACK;
      S_ACK:         w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant_go   = (r_state == S_IDLE) && i_ctrl_ready && (i_wr_req || i_rd_req);
    // On a tie the port not granted last time wins.
    w_grant_rd   = i_rd_req && (!i_wr_req || !r_last_rd);
    w_done       = r_ctrl_rw ? i_ctrl_dataval : i_ctrl_ready;
    w_expired    = (r_cnt == CNT_LAST);
    w_in_wait    = (r_state == S_WAIT_ACCEPT) || (r_state == S_WAIT_DONE);
    w_enter_wait = (w_next != r_state) && ((w_next == S_WAIT_ACCEPT) || (w_next == S_WAIT_DONE));
    w_to_ack     = (w_next == S_ACK) && (r_state != S_ACK);
    w_abort      = w_expired && (((r_state == S_WAIT_ACCEPT) && i_ctrl_ready) ||
                                 ((r_state == S_WAIT_DONE) && !w_done));
    w_capture    = (r_state == S_WAIT_DONE) && r_ctrl_rw && i_ctrl_dataval;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)           r_cnt <= '0;
    else if (w_enter_wait) r_cnt <= '0;
    else if (w_in_wait)    r_cnt <= r_cnt + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ctrl_en     <= 1'b0;
      r_ctrl_addr   <= '0;
      r_ctrl_datain <= '0;
      r_ctrl_rw     <= 1'b0;
      r_wr_ack      <= 1'b0;
      r_rd_ack      <= 1'b0;
      r_rd_data     <= '0;
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
      r_last_rd     <= 1'b0;
    end else begin
      r_ctrl_en <= w_grant_go;
      if (w_grant_go) begin
        r_ctrl_addr   <= w_grant_rd ? i_rd_addr : i_wr_addr;
        r_ctrl_datain <= i_wr_data;
        r_ctrl_rw     <= w_grant_rd;
      end
      r_wr_ack <= w_to_ack && !r_ctrl_rw;
      r_rd_ack <= w_to_ack && r_ctrl_rw;
      if (w_capture)                  r_rd_data <= i_ctrl_dataout;
      else if (w_abort && r_ctrl_rw)  r_rd_data <= '0;
      if (w_abort) r_timeout <= 1'b1;
      r_busy <= (w_next != S_IDLE);
      if (r_state == S_ACK) r_last_rd <= r_ctrl_rw;
    end
  end

  assign o_ctrl_en     = r_ctrl_en;
  assign o_ctrl_addr   = r_ctrl_addr;
  assign o_ctrl_datain = r_ctrl_datain;
  assign o_ctrl_rw     = r_ctrl_rw;
  assign o_wr_ack      = r_wr_ack;
  assign o_rd_ack      = r_rd_ack;
  assign o_rd_data     = r_rd_data;
  assign o_busy        = r_busy;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter with a behavioural sdram_ctrl model.
// Stimulus pushes expected commands/acks; a negedge monitor pops and compares.
module tb_sdram_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int TMO    = 16;

  logic              i_clk = 1'b0;
  logic              i_rstn = 1'b0;
  logic              i_wr_req = 1'b0;
  logic [ADDR_W-1:0] i_wr_addr = '0;
  logic [DATA_W-1:0] i_wr_data = '0;
  logic              o_wr_ack;
  logic              i_rd_req = 1'b0;
  logic [ADDR_W-1:0] i_rd_addr = '0;
  logic              o_rd_ack;
  logic [DATA_W-1:0] o_rd_data;
  logic [ADDR_W-1:0] o_ctrl_addr;
  logic [DATA_W-1:0] o_ctrl_datain;
  logic              o_ctrl_rw;
  logic              o_ctrl_en;
  logic              i_ctrl_ready;
  logic              i_ctrl_dataval;
  logic [DATA_W-1:0] i_ctrl_dataout;
  logic              o_busy;
  logic              o_timeout;

  always #5 i_clk = ~i_clk;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ack(o_wr_ack),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_ack(o_rd_ack), .o_rd_data(o_rd_data),
    .o_ctrl_addr(o_ctrl_addr), .o_ctrl_datain(o_ctrl_datain), .o_ctrl_rw(o_ctrl_rw),
    .o_ctrl_en(o_ctrl_en), .i_ctrl_ready(i_ctrl_ready), .i_ctrl_dataval(i_ctrl_dataval),
    .i_ctrl_dataout(i_ctrl_dataout), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  typedef struct packed {logic rw; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} cmd_t;
  typedef struct packed {logic rd; logic [DATA_W-1:0] data;} ack_t;

  cmd_t exp_cmd[$];
  ack_t exp_ack[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic push_cmd(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_cmd.push_back('{rw, a, d});
  endtask

  task automatic push_ack(input logic rd, input logic [DATA_W-1:0] d);
    exp_ack.push_back('{rd, d});
  endtask

  // Behavioural controller: takes a command, stays busy 4 cycles, then completes.
  logic [DATA_W-1:0] mem [0:255];
  logic              m_busy;
  logic              m_rw;
  logic [2:0]        m_cnt;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                stuck = 1'b0;

  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      m_busy <= 1'b0; m_rw <= 1'b0; m_cnt <= '0; m_addr <= '0; m_data <= '0;
      i_ctrl_ready <= 1'b1; i_ctrl_dataval <= 1'b0; i_ctrl_dataout <= '0;
    end else begin
      i_ctrl_dataval <= 1'b0;
      if (!m_busy) begin
        if (o_ctrl_en && !stuck) begin
          m_busy <= 1'b1; i_ctrl_ready <= 1'b0; m_cnt <= 3'd3;
          m_rw <= o_ctrl_rw; m_addr <= o_ctrl_addr; m_data <= o_ctrl_datain;
        end
      end else if (m_cnt != 3'd0) begin
        m_cnt <= m_cnt - 3'd1;
      end else begin
        m_busy <= 1'b0; i_ctrl_ready <= 1'b1;
        if (m_rw) begin
          i_ctrl_dataval <= 1'b1;
          i_ctrl_dataout <= mem[m_addr[7:0]];
        end else begin
          mem[m_addr[7:0]] <= m_data;
        end
      end
    end
  end

  logic prev_en = 1'b0;
  logic prev_dv = 1'b0;
  cmd_t lat;
  cmd_t c;
  ack_t a;

  always @(negedge i_clk) begin
    if (!i_rstn) begin
      prev_en = 1'b0;
      prev_dv = 1'b0;
    end else begin
      if (o_ctrl_en) begin
        check("en_back_to_back", prev_en, 0);
        check("en_while_not_ready", i_ctrl_ready, 1);
        lat = '{o_ctrl_rw, o_ctrl_addr, o_ctrl_datain};
        if (exp_cmd.size() == 0) check("cmd_unexpected", o_ctrl_en, 0);
        else begin
          c = exp_cmd.pop_front();
          check("cmd_rw", o_ctrl_rw, c.rw);
          check("cmd_addr", o_ctrl_addr, c.addr);
          if (!c.rw) check("cmd_datain", o_ctrl_datain, c.data);
        end
      end
      if (o_wr_ack || o_rd_ack) begin
        check("ack_onehot", o_wr_ack & o_rd_ack, 0);
        check("ctrl_addr_held", o_ctrl_addr, lat.addr);
        check("ctrl_rw_held", o_ctrl_rw, lat.rw);
        if (exp_ack.size() == 0) check("ack_unexpected", o_wr_ack | o_rd_ack, 0);
        else begin
          a = exp_ack.pop_front();
          check("ack_port", o_rd_ack, a.rd);
          if (a.rd) begin
            check("rd_data", o_rd_data, a.data);
            check("rd_ack_after_dataval", prev_dv, 1);
          end
        end
      end
      prev_en = o_ctrl_en;
      prev_dv = i_ctrl_dataval;
    end
  end

  task automatic wr_seq(input int n, input logic [ADDR_W-1:0] a0,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] dstep);
    int cyc;
    i_wr_addr = a0; i_wr_data = d0; i_wr_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc = 0;
      do begin @(posedge i_clk); #1; cyc++; end while (!o_wr_ack && cyc < 200);
      check("wr_ack_seen", o_wr_ack, 1);
      i_wr_addr = i_wr_addr + 1'b1;
      i_wr_data = i_wr_data + dstep;
    end
    i_wr_req = 1'b0;
  endtask

  task automatic rd_seq(input int n, input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] astep);
    int cyc;
    i_rd_addr = a0; i_rd_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      cyc = 0;
      do begin @(posedge i_clk); #1; cyc++; end while (!o_rd_ack && cyc < 200);
      check("rd_ack_seen", o_rd_ack, 1);
      i_rd_addr = i_rd_addr + astep;
    end
    i_rd_req = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_ctrl_en", o_ctrl_en, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_acks", {o_wr_ack, o_rd_ack}, 0);
    check("rst_rd_data", o_rd_data, 0);
    @(negedge i_clk); i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // single write then read-back
    push_cmd(1'b0, 15'h0000, 16'hBEEF); push_ack(1'b0, 16'h0);
    wr_seq(1, 15'h0000, 16'hBEEF, 16'h0);
    repeat (2) @(posedge i_clk);
    #1;
    push_cmd(1'b1, 15'h0000, 16'h0); push_ack(1'b1, 16'hBEEF);
    rd_seq(1, 15'h0000, 15'h0);
    repeat (2) @(posedge i_clk);

    // contention from reset: READ, WRITE, READ, WRITE
    @(negedge i_clk); i_rstn = 1'b0;
    push_cmd(1'b1, 15'h0000, 16'h0);    push_ack(1'b1, 16'hBEEF);
    push_cmd(1'b0, 15'h0020, 16'h1111); push_ack(1'b0, 16'h0);
    push_cmd(1'b1, 15'h0020, 16'h0);    push_ack(1'b1, 16'h1111);
    push_cmd(1'b0, 15'h0021, 16'h2222); push_ack(1'b0, 16'h0);
    fork
      wr_seq(2, 15'h0020, 16'h1111, 16'h1111);
      rd_seq(2, 15'h0000, 15'h0020);
      begin repeat (2) @(negedge i_clk); i_rstn = 1'b1; end
    join
    repeat (2) @(posedge i_clk);
    #1;

    // back-to-back writes to 0x0001..0x0008
    for (int k = 1; k <= 8; k++) begin
      push_cmd(1'b0, ADDR_W'(k), DATA_W'(16'hA000 + k));
      push_ack(1'b0, 16'h0);
    end
    wr_seq(8, 15'h0001, 16'hA001, 16'h0001);
    repeat (2) @(posedge i_clk);
    #1;
    check("no_timeout_yet", o_timeout, 0);

    // timeout: controller never takes the command
    stuck = 1'b1;
    push_cmd(1'b0, 15'h0030, 16'h5555); push_ack(1'b0, 16'h0);
    wr_seq(1, 15'h0030, 16'h5555, 16'h0);
    check("timeout_set", o_timeout, 1);
    repeat (5) @(posedge i_clk);
    #1;
    check("timeout_sticky", o_timeout, 1);
    stuck = 1'b0;

    // reset mid-read in WAIT_DONE
    push_cmd(1'b1, 15'h0020, 16'h0);
    i_rd_addr = 15'h0020; i_rd_req = 1'b1;
    cyc = 0;
    do begin @(posedge i_clk); #1; cyc++; end while (i_ctrl_ready && cyc < 50);
    check("mid_read_accept", i_ctrl_ready, 0);
    @(posedge i_clk); #1;
    check("mid_read_busy", o_busy, 1);
    check("mid_read_timeout_held", o_timeout, 1);
    #2 i_rstn = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_timeout", o_timeout, 0);
    check("arst_rd_data", o_rd_data, 0);
    check("arst_ctrl", {o_ctrl_en, o_ctrl_rw, o_ctrl_addr, o_ctrl_datain}, 0);
    check("arst_acks", {o_wr_ack, o_rd_ack}, 0);
    i_rd_req = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
    check("post_rst_idle", o_busy, 0);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("ack_queue_drained", exp_ack.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
